// File: rtl/refclk_edge_sync_if.sv
// Channel bundle for refclk_edge_sync: async inputs toward the synchroniser,
// retimed level, edge strobes and lost-reference flags back out.
interface refclk_edge_sync_if #(
  parameter int N_CH = 1
);
  logic [N_CH-1:0] i_async;
  logic [N_CH-1:0] o_sync;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_lost;

  modport master (
    output i_async,
    input  o_sync,
    input  o_rise,
    input  o_fall,
    input  o_lost
  );

  modport slave (
    input  i_async,
    output o_sync,
    output o_rise,
    output o_fall,
    output o_lost
  );
endinterface

// File: rtl/refclk_edge_sync.sv
// Multi-channel reference-clock synchroniser with glitch filter and edge strobes.
// Optional lost-reference watchdog is built when REFCLK_SYNC_WATCHDOG_EN is defined.
module refclk_edge_sync #(
  parameter int N_CH        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  refclk_edge_sync_if.slave bus
);
  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0] C_FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [FCW-1:0] C_FZERO     = FCW'(0);
  localparam logic [FCW-1:0] C_FONE      = FCW'(1);

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("refclk_edge_sync: SYNC_STAGES must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("refclk_edge_sync: FILT_LEN must be >= 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("refclk_edge_sync: TIMEOUT must be >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync [N_CH];
  logic [FCW-1:0]         r_fcnt [N_CH];
  logic [N_CH-1:0]        r_level;
  logic [N_CH-1:0]        r_rise;
  logic [N_CH-1:0]        r_fall;
  logic [N_CH-1:0]        w_s;
  logic [N_CH-1:0]        w_upd;
  logic [N_CH-1:0]        w_rise;
  logic [N_CH-1:0]        w_fall;

  // Filter decision: the retimed sample has disagreed with o_sync long enough.
  always_comb begin
    w_s   = {N_CH{1'b0}};
    w_upd = {N_CH{1'b0}};
    for (int ch = 0; ch < N_CH; ch++) begin
      w_s[ch]   = r_sync[ch][SYNC_STAGES-1];
      w_upd[ch] = (w_s[ch] != r_level[ch]) && (r_fcnt[ch] == C_FILT_LAST);
    end
    w_rise = w_upd & w_s;
    w_fall = w_upd & ~w_s;
  end

  // Synchroniser chain, filter counter, filtered level and edge strobes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_sync[ch] <= {SYNC_STAGES{1'b0}};
        r_fcnt[ch] <= C_FZERO;
      end
      r_level <= {N_CH{1'b0}};
      r_rise  <= {N_CH{1'b0}};
      r_fall  <= {N_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], bus.i_async[ch]};
        if (w_s[ch] == r_level[ch]) begin
          r_fcnt[ch] <= C_FZERO;
        end else if (w_upd[ch]) begin
          r_fcnt[ch]  <= C_FZERO;
          r_level[ch] <= w_s[ch];
        end else begin
          r_fcnt[ch] <= r_fcnt[ch] + C_FONE;
        end
      end
      r_rise <= w_rise;
      r_fall <= w_fall;
    end
  end

  assign bus.o_sync = r_level;
  assign bus.o_rise = r_rise;
  assign bus.o_fall = r_fall;

`ifdef REFCLK_SYNC_WATCHDOG_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] C_TO    = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] C_TO_M1 = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0] C_WZERO = WCW'(0);
  localparam logic [WCW-1:0] C_WONE  = WCW'(1);

  logic [WCW-1:0]  r_wcnt [N_CH];
  logic [N_CH-1:0] r_lost;

  // Watchdog: counts cycles since the last rising strobe, saturating at TIMEOUT.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_wcnt[ch] <= C_WZERO;
      end
      r_lost <= {N_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (w_rise[ch]) begin
          r_wcnt[ch] <= C_WZERO;
          r_lost[ch] <= 1'b0;
        end else if (r_wcnt[ch] != C_TO) begin
          r_wcnt[ch] <= r_wcnt[ch] + C_WONE;
          r_lost[ch] <= (r_wcnt[ch] == C_TO_M1);
        end else begin
          r_wcnt[ch] <= r_wcnt[ch];
          r_lost[ch] <= r_lost[ch];
        end
      end
    end
  end

  assign bus.o_lost = r_lost;
`else
  assign bus.o_lost = {N_CH{1'b0}};
`endif
endmodule

// File: tb/tb_refclk_edge_sync.sv
// Directed bench for refclk_edge_sync: vector table for sync/filter/strobes plus
// hand sequences for reset, watchdog and a long-period toggle on a second instance.
module tb_refclk_edge_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef REFCLK_SYNC_WATCHDOG_EN
  localparam logic [1:0] LOST_ALL = 2'b11;
`else
  localparam logic [1:0] LOST_ALL = 2'b00;
`endif

  refclk_edge_sync_if #(.N_CH(2)) bus0 ();
  refclk_edge_sync_if #(.N_CH(1)) bus1 ();

  refclk_edge_sync #(.N_CH(2), .SYNC_STAGES(2), .FILT_LEN(3), .TIMEOUT(16)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus0)
  );
  refclk_edge_sync #(.N_CH(1), .SYNC_STAGES(2), .FILT_LEN(3), .TIMEOUT(64)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] s;
    logic [1:0] r;
    logic [1:0] f;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic void add(input int n, input logic [1:0] a, input logic [1:0] s,
                              input logic [1:0] r, input logic [1:0] f);
    vec_t v;
    v.a = a; v.s = s; v.r = r; v.f = f;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [1:0] lost_lo;
  int rise_at[$];
  logic lost_seen;
  int cyc;

  initial begin
    bus0.i_async = 2'b00;
    bus1.i_async = 1'b0;
    lost_lo = LOST_ALL & 2'b01;

    // Expected per edge: filter sees the input two edges late, needs 3 samples.
    add(4, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b01, 2'b01, 2'b00);
    add(1, 2'b01, 2'b01, 2'b00, 2'b00);
    add(4, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2, 2'b01, 2'b00, 2'b00, 2'b00);
    add(3, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, 2'b10, 2'b00, 2'b00, 2'b00);
    add(1, 2'b10, 2'b10, 2'b10, 2'b00);
    add(1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(4, 2'b01, 2'b10, 2'b00, 2'b00);
    add(1, 2'b01, 2'b01, 2'b01, 2'b10);
    add(1, 2'b01, 2'b01, 2'b00, 2'b00);

    #12;
    chk("reset_outs0", {2'b00, bus0.o_sync, bus0.o_rise, bus0.o_fall}, 8'h00);
    chk("reset_lost", {4'h0, bus1.o_lost, 1'b0, bus0.o_lost}, 8'h00);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus0.i_async = tbl[i].a;
      step(1);
      chk($sformatf("vec%0d", i), {2'b00, bus0.o_sync, bus0.o_rise, bus0.o_fall},
          {2'b00, tbl[i].s, tbl[i].r, tbl[i].f});
    end

    // Bring both channels high, then reset asynchronously between edges.
    bus0.i_async = 2'b11;
    step(5);
    chk("pre_rst_sync", {6'h00, bus0.o_sync}, {6'h00, 2'b11});
    chk("pre_rst_rise", {6'h00, bus0.o_rise}, {6'h00, 2'b10});
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus0.o_sync, bus0.o_rise, bus0.o_fall, bus0.o_lost}, 8'h00);
    bus0.i_async = 2'b00;
    step(1);
    rst_n = 1'b1;

    step(15);
    chk("post_rel", {2'b00, bus0.o_sync, bus0.o_rise, bus0.o_fall}, 8'h00);
    chk("lost_15", {6'h00, bus0.o_lost}, 8'h00);
    step(1);
    chk("lost_16", {6'h00, bus0.o_lost}, {6'h00, LOST_ALL});

    // Rise on ch1 clears its flag on the same edge; re-arms after 16 cycles.
    bus0.i_async = 2'b10;
    step(4);
    chk("wd_pre_rise", {4'h0, bus0.o_rise, bus0.o_lost}, {4'h0, 2'b00, LOST_ALL});
    step(1);
    chk("wd_rise", {2'b00, bus0.o_sync, bus0.o_rise, bus0.o_lost},
        {2'b00, 2'b10, 2'b10, lost_lo});
    step(15);
    chk("wd_15", {6'h00, bus0.o_lost}, {6'h00, lost_lo});
    step(1);
    chk("wd_16", {6'h00, bus0.o_lost}, {6'h00, LOST_ALL});
    bus0.i_async = 2'b00;
    step(5);
    chk("wd_fall_keeps", {4'h0, bus0.o_fall, bus0.o_lost}, {4'h0, 2'b10, LOST_ALL});
    bus0.i_async = 2'b10;
    step(5);
    chk("wd_rerise", {4'h0, bus0.o_rise, bus0.o_lost}, {4'h0, 2'b10, lost_lo});

    // Long-period toggle on the TIMEOUT=64 instance.
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    lost_seen = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (cyc % 20 == 0) bus1.i_async = ~bus1.i_async;
      step(1);
      if (bus1.o_rise[0]) rise_at.push_back(cyc);
      if (bus1.o_lost[0]) lost_seen = 1'b1;
    end
    chk("t6_rise_cnt", 8'(rise_at.size()), 8'd5);
    if (rise_at.size() > 0) chk("t6_first", 8'(rise_at[0]), 8'd4);
    for (int k = 1; k < rise_at.size(); k++)
      chk($sformatf("t6_period%0d", k), 8'(rise_at[k] - rise_at[k-1]), 8'd40);
    chk("t6_no_lost", {7'h00, lost_seen}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
